// File: rtl/debug_probe_if.sv
// Probe bus between the board-side controller and debug_probe: mode/select/channel
// data in, registered display value and active channel out.
interface debug_probe_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int OUTPUT_WIDTH  = 8,
  parameter int SEL_WIDTH     = 2
);
  logic [1:0]                            mode_i;
  logic [SEL_WIDTH-1:0]                  select_i;
  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_data_i;
  logic [OUTPUT_WIDTH-1:0]               output_value_o;
  logic [SEL_WIDTH-1:0]                  active_channel_o;

  modport master (
    output mode_i, select_i, channel_data_i,
    input  output_value_o, active_channel_o
  );

  modport slave (
    input  mode_i, select_i, channel_data_i,
    output output_value_o, active_channel_o
  );
endinterface

// File: rtl/debug_probe.sv
// Debug/display front end: channel select with direct/scan/freeze modes, plus a
// synchronised, debounced pushbutton producing a level and a single-step pulse.
module debug_probe #(
  parameter int NUM_CHANNELS    = 4,
  parameter int CHANNEL_WIDTH   = 8,
  parameter int OUTPUT_WIDTH    = 8,
  parameter int SEL_WIDTH       = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_PERIOD     = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         switch_i,
  output logic         switch_level_o,
  output logic         step_pulse_o,
  debug_probe_if.slave probe
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  typedef enum logic [1:0] {
    MODE_DIRECT     = 2'b00,
    MODE_SCAN       = 2'b01,
    MODE_FREEZE     = 2'b10,
    MODE_DIRECT_ALT = 2'b11
  } mode_e;

  logic                    sync1_q, sync2_q;
  logic                    level_q, level_d;
  logic                    level_dly_q;
  logic                    pulse_q, pulse_d;
  logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
  logic [SCW-1:0]          scan_cnt_q, scan_cnt_d;
  logic [SEL_WIDTH-1:0]    act_q, act_d;
  logic [OUTPUT_WIDTH-1:0] out_q, out_d;
  logic [SEL_WIDTH-1:0]    next_chan;
  logic                    scan_terminal;
  mode_e                   mode;

  assign mode = mode_e'(probe.mode_i);

  // Indices beyond the populated channels read as zero.
  function automatic logic [OUTPUT_WIDTH-1:0] chan_value(
    input logic [SEL_WIDTH-1:0]                  idx,
    input logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] data
  );
    logic [OUTPUT_WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (idx == SEL_WIDTH'(k)) begin
        v = OUTPUT_WIDTH'(data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
      end
    end
    return v;
  endfunction

  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
    // Pulse lands the cycle after the debounced level has risen.
    pulse_d = level_q & ~level_dly_q;
  end

  assign scan_terminal = (scan_cnt_q == SCW'(SCAN_PERIOD - 1));
  assign next_chan     = (act_q == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0 : act_q + SEL_WIDTH'(1);

  // Counter is held clear outside SCAN so entering SCAN always starts at zero.
  always_comb begin
    scan_cnt_d = '0;
    act_d      = act_q;
    out_d      = out_q;
    case (mode)
      MODE_SCAN: begin
        if (scan_terminal || pulse_q) begin
          act_d = next_chan;
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
        out_d = chan_value(act_d, probe.channel_data_i);
      end
      MODE_FREEZE: begin
        if (pulse_q) begin
          act_d = probe.select_i;
          out_d = chan_value(probe.select_i, probe.channel_data_i);
        end
      end
      default: begin
        act_d = probe.select_i;
        out_d = chan_value(probe.select_i, probe.channel_data_i);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      deb_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      act_q       <= '0;
      out_q       <= '0;
    end else begin
      sync1_q     <= switch_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
      deb_cnt_q   <= deb_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      act_q       <= act_d;
      out_q       <= out_d;
    end
  end

  assign switch_level_o         = level_q;
  assign step_pulse_o           = pulse_q;
  assign probe.output_value_o   = out_q;
  assign probe.active_channel_o = act_q;

endmodule

// File: tb/tb_debug_probe.sv
// Directed bench for debug_probe: a 4x8 instance for modes/debounce/reset and a
// 3x5 instance for zero-extension and out-of-range select.
module tb_debug_probe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic lvl_a, pulse_a, lvl_b, pulse_b;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  debug_probe_if #(.NUM_CHANNELS(4), .CHANNEL_WIDTH(8), .OUTPUT_WIDTH(8), .SEL_WIDTH(2)) if_a ();
  debug_probe_if #(.NUM_CHANNELS(3), .CHANNEL_WIDTH(5), .OUTPUT_WIDTH(8), .SEL_WIDTH(2)) if_b ();

  debug_probe #(
    .NUM_CHANNELS(4), .CHANNEL_WIDTH(8), .OUTPUT_WIDTH(8), .SEL_WIDTH(2),
    .DEBOUNCE_CYCLES(16), .SCAN_PERIOD(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .switch_i(sw),
    .switch_level_o(lvl_a), .step_pulse_o(pulse_a), .probe(if_a)
  );

  debug_probe #(
    .NUM_CHANNELS(3), .CHANNEL_WIDTH(5), .OUTPUT_WIDTH(8), .SEL_WIDTH(2),
    .DEBOUNCE_CYCLES(16), .SCAN_PERIOD(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .switch_i(sw),
    .switch_level_o(lvl_b), .step_pulse_o(pulse_b), .probe(if_b)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] data_a;
    logic [14:0] data_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int npulse, output int first);
    npulse = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pulse_a === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int np, fp;
    logic [7:0] exp_bytes [4];
    logic [7:0] ch0_val;

    // b: ch0=05 ch1=0A ch2=1F; second pattern ch0=1F ch1=00 ch2=10
    vecs[0] = '{2'b00, 2'd1, 32'h7EC32A11, 15'h7D45, 8'h2A, 8'h0A};
    vecs[1] = '{2'b00, 2'd2, 32'h7EC32A11, 15'h7D45, 8'hC3, 8'h1F};
    vecs[2] = '{2'b00, 2'd3, 32'h7EC32A11, 15'h7D45, 8'h7E, 8'h00};
    vecs[3] = '{2'b11, 2'd0, 32'h7EC32A11, 15'h7D45, 8'h11, 8'h05};
    vecs[4] = '{2'b11, 2'd3, 32'hFF00A55A, 15'h401F, 8'hFF, 8'h00};
    vecs[5] = '{2'b00, 2'd0, 32'hFF00A55A, 15'h401F, 8'h5A, 8'h1F};
    vecs[6] = '{2'b11, 2'd2, 32'hFF00A55A, 15'h401F, 8'h00, 8'h10};
    vecs[7] = '{2'b00, 2'd1, 32'hFF00A55A, 15'h401F, 8'hA5, 8'h00};

    if_a.mode_i = 2'b00; if_a.select_i = 2'd0; if_a.channel_data_i = 32'h7EC32A11;
    if_b.mode_i = 2'b00; if_b.select_i = 2'd0; if_b.channel_data_i = 15'h7D45;

    // Reset state
    #12;
    check("rst_out_a", 32'(if_a.output_value_o), 32'h0);
    check("rst_act_a", 32'(if_a.active_channel_o), 32'h0);
    check("rst_lvl_a", 32'(lvl_a), 32'h0);
    check("rst_pulse_a", 32'(pulse_a), 32'h0);
    check("rst_out_b", 32'(if_b.output_value_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // DIRECT table, one clock latency
    for (int i = 0; i < 8; i++) begin
      if_a.mode_i = vecs[i].mode; if_a.select_i = vecs[i].sel; if_a.channel_data_i = vecs[i].data_a;
      if_b.mode_i = vecs[i].mode; if_b.select_i = vecs[i].sel; if_b.channel_data_i = vecs[i].data_b;
      tick();
      check($sformatf("vec%0d_out_a", i), 32'(if_a.output_value_o), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_act_a", i), 32'(if_a.active_channel_o), 32'(vecs[i].sel));
      check($sformatf("vec%0d_out_b", i), 32'(if_b.output_value_o), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_act_b", i), 32'(if_b.active_channel_o), 32'(vecs[i].sel));
    end

    // Bouncing switch, then steady high, then release
    if_a.mode_i = 2'b00;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      sw = ((i / 3) % 2) != 0;
      tick();
      if (pulse_a === 1'b1) np++;
    end
    sw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pulse_a === 1'b1) np++;
    end
    check("bounce_no_pulse", 32'(np), 32'd0);
    check("bounce_level", 32'(lvl_a), 32'h0);
    sw = 1'b1;
    run(30, np, fp);
    check("steady_pulse_count", 32'(np), 32'd1);
    check("steady_pulse_cycle", 32'(fp), 32'd19);
    check("steady_level", 32'(lvl_a), 32'h1);
    sw = 1'b0;
    run(25, np, fp);
    check("release_no_pulse", 32'(np), 32'd0);
    check("release_level", 32'(lvl_a), 32'h0);

    // SCAN from ch0, step pulse coinciding with terminal count at edge 20
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    if_a.channel_data_i = 32'h44332211;
    if_a.select_i = 2'd0;
    tick();
    check("scan_pre_act", 32'(if_a.active_channel_o), 32'h0);
    if_a.mode_i = 2'b01;
    if_a.select_i = 2'd3;
    sw = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      check($sformatf("scan_e%0d_act", e), 32'(if_a.active_channel_o), 32'((e / 4) % 4));
      check($sformatf("scan_e%0d_out", e), 32'(if_a.output_value_o), 32'(exp_bytes[(e / 4) % 4]));
    end

    // SCAN step pulse at count 1: forced advance and counter restart
    sw = 1'b0;
    if_a.mode_i = 2'b00;
    if_a.select_i = 2'd2;
    run(20, np, fp);
    check("scanb_lvl_low", 32'(lvl_a), 32'h0);
    sw = 1'b1;
    run(18, np, fp);
    if_a.mode_i = 2'b01;
    tick();
    check("scanb_e19_act", 32'(if_a.active_channel_o), 32'h2);
    tick();
    check("scanb_e20_act", 32'(if_a.active_channel_o), 32'h3);
    check("scanb_e20_out", 32'(if_a.output_value_o), 32'h44);
    tick(); tick(); tick();
    check("scanb_e23_act", 32'(if_a.active_channel_o), 32'h3);
    tick();
    check("scanb_e24_act", 32'(if_a.active_channel_o), 32'h0);
    check("scanb_e24_out", 32'(if_a.output_value_o), 32'h11);

    // FREEZE with ch0 changing every cycle, snapshot on step pulse
    sw = 1'b0;
    if_a.mode_i = 2'b00;
    if_a.select_i = 2'd1;
    if_a.channel_data_i = 32'h44332280;
    run(20, np, fp);
    check("frz_pre_out", 32'(if_a.output_value_o), 32'h22);
    if_a.mode_i = 2'b10;
    if_a.select_i = 2'd0;
    sw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ch0_val = 8'h80 + 8'(i);
      if_a.channel_data_i[7:0] = ch0_val;
      tick();
      check($sformatf("frz_e%0d_out", i + 1), 32'(if_a.output_value_o), (i + 1 < 20) ? 32'h22 : 32'h93);
      check($sformatf("frz_e%0d_act", i + 1), 32'(if_a.active_channel_o), (i + 1 < 20) ? 32'h1 : 32'h0);
    end
    if_a.mode_i = 2'b00;
    if_a.select_i = 2'd2;
    tick();
    check("unfreeze_out", 32'(if_a.output_value_o), 32'h33);
    check("unfreeze_act", 32'(if_a.active_channel_o), 32'h2);

    // Asynchronous reset mid-scan and mid-debounce, then clean restart
    sw = 1'b0;
    if_a.mode_i = 2'b01;
    run(6, np, fp);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_a", 32'(if_a.output_value_o), 32'h0);
    check("arst_act_a", 32'(if_a.active_channel_o), 32'h0);
    check("arst_lvl_a", 32'(lvl_a), 32'h0);
    check("arst_pulse_a", 32'(pulse_a), 32'h0);
    check("arst_out_b", 32'(if_b.output_value_o), 32'h0);
    if_a.mode_i = 2'b00;
    if_a.select_i = 2'd1;
    sw = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_out", 32'(if_a.output_value_o), 32'h22);
    run(16, np, fp);
    check("post_rst_lvl_e17", 32'(lvl_a), 32'h0);
    tick();
    check("post_rst_lvl_e18", 32'(lvl_a), 32'h1);
    tick();
    check("post_rst_pulse_e19", 32'(pulse_a), 32'h1);
    tick();
    check("post_rst_pulse_e20", 32'(pulse_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
